// File: rtl/regfile_pkg.sv
// Shared register-file writeback definitions: widths, register count and the request record.
package regfile_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] path;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous writeback FIFO; also exposes each slot's valid bit and destination so the
// arbiter can build the pending-destination mask.
module wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [AddrW-1:0]            path_i,
  input  logic [DataW-1:0]            data_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [AddrW-1:0]            head_path_o,
  output logic [DataW-1:0]            head_data_o,
  output logic [Depth-1:0]            ent_valid_o,
  output logic [Depth-1:0][AddrW-1:0] ent_path_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  logic [Depth-1:0][AddrW-1:0] path_q;
  logic [Depth-1:0][DataW-1:0] data_q;
  logic                       do_push, do_pop;

  assign full_o      = (count_q == CntW'(Depth));
  assign empty_o     = (count_q == '0);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign head_path_o = path_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign ent_path_o  = path_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    ent_valid_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      ent_valid_o[i] = ({1'b0, PtrW'(i) - rd_ptr_q} < count_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      path_q[wr_ptr_q] <= path_i;
      data_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register-file write port between ALU (req0) and load (req1)
// writeback FIFOs, with registered port outputs and a pending-destination mask.
module regfile_write_arbiter
  import regfile_pkg::NUM_REGS;
  import regfile_pkg::ZERO_REG;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_path,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_path,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   Writepath,
  output logic [DATA_W-1:0]   Writedata,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                idle
);

  localparam logic [ADDR_W-1:0] ZeroPath = ADDR_W'(ZERO_REG);

  logic                         full0, full1, empty0, empty1;
  logic                         grant0, grant1;
  logic [ADDR_W-1:0]            head_path0, head_path1;
  logic [DATA_W-1:0]            head_data0, head_data1;
  logic [DEPTH-1:0]             ent_valid0, ent_valid1;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_path0, ent_path1;

  logic              last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_path_q, write_path_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  assign req0_ready = !full0;
  assign req1_ready = !full1;

  wb_fifo #(
    .Depth (DEPTH),
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_fifo0 (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .push_i      (req0_valid),
    .pop_i       (grant0),
    .path_i      (req0_path),
    .data_i      (req0_data),
    .full_o      (full0),
    .empty_o     (empty0),
    .head_path_o (head_path0),
    .head_data_o (head_data0),
    .ent_valid_o (ent_valid0),
    .ent_path_o  (ent_path0)
  );

  wb_fifo #(
    .Depth (DEPTH),
    .AddrW (ADDR_W),
    .DataW (DATA_W)
  ) u_fifo1 (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .push_i      (req1_valid),
    .pop_i       (grant1),
    .path_i      (req1_path),
    .data_i      (req1_data),
    .full_o      (full1),
    .empty_o     (empty1),
    .head_path_o (head_path1),
    .head_data_o (head_data1),
    .ent_valid_o (ent_valid1),
    .ent_path_o  (ent_path1)
  );

  // last_grant holds the index of the requester served most recently.
  always_comb begin
    grant0       = !empty0 && (empty1 || last_grant_q);
    grant1       = !empty1 && (empty0 || !last_grant_q);
    last_grant_d = last_grant_q;
    reg_write_d  = 1'b0;
    write_path_d = write_path_q;
    write_data_d = write_data_q;
    if (grant0) begin
      last_grant_d = 1'b0;
      reg_write_d  = (head_path0 != ZeroPath);
      write_path_d = head_path0;
      write_data_d = head_data0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
      reg_write_d  = (head_path1 != ZeroPath);
      write_path_d = head_path1;
      write_data_d = head_data1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
      reg_write_q  <= 1'b0;
      write_path_q <= '0;
      write_data_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      write_path_q <= write_path_d;
      write_data_q <= write_data_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid0[i]) pending_mask[ent_path0[i]] = 1'b1;
      if (ent_valid1[i]) pending_mask[ent_path1[i]] = 1'b1;
    end
    if (reg_write_q) pending_mask[write_path_q] = 1'b1;
    pending_mask[ZeroPath] = 1'b0;
  end

  assign RegWrite  = reg_write_q;
  assign Writepath = write_path_q;
  assign Writedata = write_data_q;
  assign idle      = empty0 && empty1 && !reg_write_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: per-requester drivers feed queues, a monitor scores port writes against an
// expected-write queue, and the main sequence adds cycle-exact spot checks.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                req0_valid, req0_ready, req1_valid, req1_ready;
  logic [ADDR_W-1:0]   req0_path, req1_path, Writepath;
  logic [DATA_W-1:0]   req0_data, req1_data, Writedata;
  logic                RegWrite, idle;
  logic [NUM_REGS-1:0] pending_mask;

  int n_checks = 0;
  int n_pass   = 0;

  wb_req_t q0[$];
  wb_req_t q1[$];
  wb_req_t exp_q[$];
  logic [DATA_W-1:0] rf [NUM_REGS];

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .DEPTH  (2),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_path    (req0_path),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_path    (req1_path),
    .req1_data    (req1_data),
    .RegWrite     (RegWrite),
    .Writepath    (Writepath),
    .Writedata    (Writedata),
    .pending_mask (pending_mask),
    .idle         (idle)
  );

  // Minimal register file model fed by the write port.
  always @(posedge clock) begin
    if (RegWrite) rf[Writepath] <= Writedata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  function automatic wb_req_t mk(input int unsigned p, input logic [DATA_W-1:0] d);
    wb_req_t r;
    r.path = ADDR_W'(p);
    r.data = d;
    return r;
  endfunction

  initial begin : drv0
    logic fire;
    req0_valid = 1'b0;
    req0_path  = '0;
    req0_data  = '0;
    forever begin
      @(negedge clock);
      if (q0.size() != 0) begin
        req0_valid = 1'b1;
        req0_path  = q0[0].path;
        req0_data  = q0[0].data;
      end else begin
        req0_valid = 1'b0;
      end
      fire = req0_valid && req0_ready;
      @(posedge clock);
      if (fire && reset_n && q0.size() != 0) void'(q0.pop_front());
    end
  end

  initial begin : drv1
    logic fire;
    req1_valid = 1'b0;
    req1_path  = '0;
    req1_data  = '0;
    forever begin
      @(negedge clock);
      if (q1.size() != 0) begin
        req1_valid = 1'b1;
        req1_path  = q1[0].path;
        req1_data  = q1[0].data;
      end else begin
        req1_valid = 1'b0;
      end
      fire = req1_valid && req1_ready;
      @(posedge clock);
      if (fire && reset_n && q1.size() != 0) void'(q1.pop_front());
    end
  end

  initial begin : monitor
    wb_req_t e;
    forever begin
      @(negedge clock);
      if (reset_n && RegWrite) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got write to %0d data 0x%0h, want no write",
                   Writepath, Writedata);
        end else begin
          e = exp_q.pop_front();
          chk("port_path", 64'(Writepath), 64'(e.path));
          chk("port_data", 64'(Writedata), 64'(e.data));
          chk("port_mask_bit", 64'(pending_mask[Writepath]), 64'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
      @(negedge clock);
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clock);
    chk({name, "_idle"}, 64'(idle), 64'd1);
  endtask

  initial begin : main
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_ready0", 64'(req0_ready), 64'd1);
    chk("rst_ready1", 64'(req1_ready), 64'd1);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_path_data", {27'd0, Writepath, Writedata}, 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_idle", 64'(idle), 64'd1);

    // Contention straight out of reset: req0 wins first, then strict alternation.
    @(posedge clock); #2;
    q0.push_back(mk(1, 32'hA000_0001)); q0.push_back(mk(2, 32'hA000_0002));
    q0.push_back(mk(3, 32'hA000_0003));
    q1.push_back(mk(10, 32'hB000_000A)); q1.push_back(mk(11, 32'hB000_000B));
    q1.push_back(mk(12, 32'hB000_000C));
    exp_q.push_back(mk(1, 32'hA000_0001)); exp_q.push_back(mk(10, 32'hB000_000A));
    exp_q.push_back(mk(2, 32'hA000_0002)); exp_q.push_back(mk(11, 32'hB000_000B));
    exp_q.push_back(mk(3, 32'hA000_0003)); exp_q.push_back(mk(12, 32'hB000_000C));
    repeat (3) @(negedge clock);
    chk("cont_ready1_full", 64'(req1_ready), 64'd0);
    chk("cont_ready0", 64'(req0_ready), 64'd1);
    chk("cont_mask", 64'(pending_mask), 64'h0000_0C06);
    @(negedge clock);
    chk("cont_ready0_full", 64'(req0_ready), 64'd0);
    wait_drain("cont_drain");

    // Single write and register-file commit.
    @(posedge clock); #2;
    q0.push_back(mk(6, 32'hFFFF_FFFF));
    exp_q.push_back(mk(6, 32'hFFFF_FFFF));
    repeat (2) @(negedge clock);
    chk("single_queued_mask", 64'(pending_mask), 64'h40);
    chk("single_queued_rw", 64'(RegWrite), 64'd0);
    @(negedge clock);
    chk("single_rw", 64'(RegWrite), 64'd1);
    chk("single_port_mask", 64'(pending_mask), 64'h40);
    @(negedge clock);
    chk("single_rf6", 64'(rf[6]), 64'hFFFF_FFFF);
    chk("single_mask_clear", 64'(pending_mask), 64'd0);
    wait_drain("single_drain");

    // $0 entry consumes a slot but never writes.
    @(posedge clock); #2;
    q1.push_back(mk(0, 32'hDEAD_BEEF)); q1.push_back(mk(5, 32'h5555_0005));
    exp_q.push_back(mk(5, 32'h5555_0005));
    repeat (2) @(negedge clock);
    chk("zero_queued_mask", 64'(pending_mask), 64'd0);
    chk("zero_queued_rw", 64'(RegWrite), 64'd0);
    @(negedge clock);
    chk("zero_slot_rw", 64'(RegWrite), 64'd0);
    chk("zero_slot_path", 64'(Writepath), 64'd0);
    chk("zero_slot_mask", 64'(pending_mask), 64'h20);
    @(negedge clock);
    chk("zero_next_rw", 64'(RegWrite), 64'd1);
    wait_drain("zero_drain");

    // req0 fills while req1 competes; ready returns the cycle after its pop.
    @(posedge clock); #2;
    q0.push_back(mk(20, 32'hC000_0014)); q0.push_back(mk(21, 32'hC000_0015));
    q0.push_back(mk(22, 32'hC000_0016)); q0.push_back(mk(23, 32'hC000_0017));
    q1.push_back(mk(25, 32'hD000_0019)); q1.push_back(mk(26, 32'hD000_001A));
    exp_q.push_back(mk(20, 32'hC000_0014)); exp_q.push_back(mk(25, 32'hD000_0019));
    exp_q.push_back(mk(21, 32'hC000_0015)); exp_q.push_back(mk(26, 32'hD000_001A));
    exp_q.push_back(mk(22, 32'hC000_0016)); exp_q.push_back(mk(23, 32'hC000_0017));
    repeat (4) @(negedge clock);
    chk("full_ready0_low", 64'(req0_ready), 64'd0);
    @(negedge clock);
    chk("full_ready0_back", 64'(req0_ready), 64'd1);
    wait_drain("full_drain");

    // Asynchronous reset with three entries still queued.
    @(posedge clock); #2;
    q0.push_back(mk(7, 32'hE000_0007)); q0.push_back(mk(8, 32'hE000_0008));
    q1.push_back(mk(9, 32'hE000_0009)); q1.push_back(mk(13, 32'hE000_000D));
    exp_q.push_back(mk(9, 32'hE000_0009));
    repeat (3) @(negedge clock);
    chk("midrst_mask_before", 64'(pending_mask), 64'h0000_2380);
    #2;
    q0.delete();
    q1.delete();
    reset_n = 1'b0;
    #1;
    chk("midrst_rw", 64'(RegWrite), 64'd0);
    chk("midrst_path_data", {27'd0, Writepath, Writedata}, 64'd0);
    chk("midrst_mask", 64'(pending_mask), 64'd0);
    chk("midrst_idle", 64'(idle), 64'd1);
    chk("midrst_ready", {62'd0, req0_ready, req1_ready}, 64'd3);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(negedge clock);
    chk("after_rst_idle", 64'(idle), 64'd1);
    chk("after_rst_mask", 64'(pending_mask), 64'd0);
    chk("after_rst_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (RegWrite/Writepath/Writedata) between two writeback requesters: req0 is the ALU writeback and req1 is the load writeback. Each requester has a small FIFO. A round-robin arbiter drains the FIFO heads into registered write-port outputs, one write per cycle. Writes to $0 are consumed but never issued. A pending-destination mask is exported for hazard detection.

Parameters:
DEPTH, 2, entries per requester FIFO; power of two, >=2
DATA_W, 32, write data width
ADDR_W, 5, register index width (32 registers)

Ports:
clock  input  1  rising-edge clock, shared with registerFile
reset_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a write
req0_ready  output  1  requester 0 FIFO not full
req0_path  input  ADDR_W  requester 0 destination register
req0_data  input  DATA_W  requester 0 write data
req1_valid  input  1  requester 1 has a write
req1_ready  output  1  requester 1 FIFO not full
req1_path  input  ADDR_W  requester 1 destination register
req1_data  input  DATA_W  requester 1 write data
RegWrite  output  1  write enable to registerFile, registered
Writepath  output  ADDR_W  write index to registerFile, registered
Writedata  output  DATA_W  write data to registerFile, registered
pending_mask  output  32  bit i = a write to register i is queued or on the port
idle  output  1  both FIFOs empty and RegWrite=0

Behaviour:
- Reset (async, reset_n=0): both FIFOs empty, pointers and counts 0, RegWrite=0, Writepath=0, Writedata=0, last_grant=1 so req0 wins first, pending_mask=0, idle=1, reqN_ready=1. Reset mid-operation discards all queued entries, and no write is issued.
- Accept: a push occurs at an edge where reqN_valid && reqN_ready. reqN_ready = !fullN and depends only on state. A full FIFO does not accept in the cycle it pops.
- Arbitrate each cycle over non-empty FIFO heads:
  - Only one non-empty: that one is granted.
  - Both non-empty: the requester other than last_grant is granted.
  - last_grant updates only on a grant.
- Pop: the granted head is popped at the edge, and the output registers load at the same edge.
  - RegWrite <= (head_path != 0).
  - Writepath <= head_path.
  - Writedata <= head_data.
  - With no grant: RegWrite <= 0, and Writepath/Writedata hold their values.
- Latency: a request accepted at edge k is popped at edge k+1 at the earliest, with RegWrite=1 during cycle k+1. registerFile commits it at edge k+2.
- Throughput: one write per cycle total. A single requester streams at full rate. Two saturating requesters alternate 0,1,0,1.
- Ordering: in-order per requester. No ordering is guaranteed across requesters. The producer must not issue the same destination from both requesters concurrently.
- $0 rule: an entry with path 0 is accepted and popped and consumes its arbitration slot and round-robin turn. It produces RegWrite=0 in its output cycle.
- Same-cycle push and pop on a non-full FIFO: both happen, and the count is unchanged.
- pending_mask is combinational from state. Bit i=1 if any valid entry in either FIFO has path i, or if RegWrite=1 and Writepath=i. Bit 0 is always 0.
- idle = empty0 && empty1 && !RegWrite.
- Pointers wrap modulo DEPTH. Full/empty are derived from a count of width clog2(DEPTH)+1.

Decomposition:
- Shared package regfile_pkg holds:
  - constants ADDR_W=5, DATA_W=32, NUM_REGS=32, ZERO_REG=0;
  - typedef wb_req_t {path[ADDR_W-1:0], data[DATA_W-1:0]}.
- One sub-module, wb_fifo: a synchronous FIFO with async active-low reset. It exposes push, pop, full, empty, head, and a per-entry valid+path view for pending_mask. It is instantiated twice.

Test Plan:
- Reset then idle: idle=1, RegWrite=0, req0_ready=req1_ready=1, pending_mask=0.
- Single write: req0 path=6, data=FFFF_FFFF for one cycle.
  - Next cycle: RegWrite=1, Writepath=6, Writedata=FFFF_FFFF, pending_mask[6]=1.
  - registerFile reads FFFF_FFFF at index 6 after the following edge.
- Contention: both requesters continuously valid, req0 paths 1,2,3 and req1 paths 10,11,12.
  - Port sequence: 1,10,2,11,3,12.
  - Back-pressure: readyN deasserts when its FIFO holds DEPTH entries.
- $0 suppression: req1 path=0, data=DEAD_BEEF.
  - Entry is popped with RegWrite=0 in its output cycle, and pending_mask stays 0.
  - A following req1 path=5 write issues one cycle later.
- Full FIFO: fill req0 with 2 entries while req1 is also busy.
  - req0_ready=0 while full.
  - req0_ready=1 the cycle after a pop, and no entry is lost or duplicated.
- Reset mid-stream: drop reset_n asynchronously with 3 entries queued.
  - Outputs zero immediately, and no RegWrite occurs afterwards.
  - pending_mask=0, idle=1.
